// File: rtl/bias_add_sequencer.sv
// bias_add_sequencer: seeds each output pixel with its group bias, saturating-accumulates
// N_ACC partial-sum beats per lane, and steps pixel/group counters over one layer slice.
module bias_add_sequencer #(
    parameter int N_adder_tree = 16,
    parameter int DW           = 18,
    parameter int N_GROUPS     = 4,
    parameter int N_ACC        = 9,
    parameter int N_PIX        = 196
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [N_GROUPS*N_adder_tree*DW-1:0]  bias_bank,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_adder_tree*DW-1:0]           in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_adder_tree*DW-1:0]           out_data,
    output logic [$clog2(N_GROUPS)-1:0]          group_idx,
    output logic                                 busy,
    output logic                                 done
);
    localparam int LW = N_adder_tree * DW;
    localparam int GW = $clog2(N_GROUPS);
    localparam int AW = N_ACC > 1 ? $clog2(N_ACC) : 1;
    localparam int PW = N_PIX > 1 ? $clog2(N_PIX) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] acc_cnt;
    logic [PW-1:0] pix;
    logic [GW-1:0] grp;
    logic [LW-1:0] acc, acc_nx;
    logic [DW-1:0] base;
    logic [DW:0]   sum;
    logic          beat, hs, last_beat, last_pix, last_grp;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == EMIT;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign out_data  = acc;
    assign group_idx = grp;
    assign beat      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign last_beat = acc_cnt == AW'(N_ACC - 1);
    assign last_pix  = pix == PW'(N_PIX - 1);
    assign last_grp  = grp == GW'(N_GROUPS - 1);

    // Sum in DW+1 bits; a sign disagreement between the top two bits means overflow.
    always_comb begin
        acc_nx = acc;
        base   = '0;
        sum    = '0;
        for (int i = 0; i < N_adder_tree; i++) begin
            base = acc_cnt == '0 ? bias_bank[int'(grp)*LW + i*DW +: DW] : acc[i*DW +: DW];
            sum  = {base[DW-1], base} + {in_data[i*DW + DW - 1], in_data[i*DW +: DW]};
            acc_nx[i*DW +: DW] = sum[DW] != sum[DW-1] ? {sum[DW], {(DW-1){~sum[DW]}}} : sum[DW-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ACCUM : IDLE;
            ACCUM:   state_nx = beat && last_beat ? EMIT : ACCUM;
            EMIT:    state_nx = !hs ? EMIT : (last_pix && last_grp ? DONE : ACCUM);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_cnt <= '0;
            pix     <= '0;
            grp     <= '0;
            acc     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                acc_cnt <= '0;
                pix     <= '0;
                grp     <= '0;
            end
            if (beat) begin
                acc     <= acc_nx;
                acc_cnt <= last_beat ? '0 : acc_cnt + 1'b1;
            end
            if (hs) begin
                pix <= last_pix ? '0 : pix + 1'b1;
                if (last_pix)
                    grp <= last_grp ? '0 : grp + 1'b1;
            end
        end
    end
endmodule
